// File: rtl/fp_square.sv
// fp_square: iterative IEEE-754 squarer (x*x) for one operand.
//
// An operand is accepted on a start pulse while the unit is IDLE or DONE.
// The significand product is built one multiplier bit per cycle with an
// MSB-first shift-add, then normalised, rounded and range-checked.
// Special operands (zero/subnormal, inf, NaN) bypass the multiplier.
// The result is held on o_sign/o_exp/o_frac with ready high until the next
// accepted start.
//
// Build option:
//   FP_SQUARE_RNE_EN  defined     -> round to nearest, ties to even
//                     not defined -> truncate (round toward zero)
//   Latency and all other behaviour are the same in both builds.
module fp_square #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52,
    parameter int BIAS   = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              i_sign,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [FRAC_W-1:0] i_frac,
    output logic              ready,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [FRAC_W-1:0] o_frac
);

    localparam int SIG_W  = FRAC_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int EW     = EXP_W + 2;
    localparam int CNT_W  = $clog2(SIG_W);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_NORM = 3'd2;
    localparam logic [2:0] S_SPEC = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S = '0;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FRAC_W);

    // State and datapath registers
    logic [2:0]        state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [PROD_W-1:0] acc_q,      acc_d;
    logic [SIG_W-1:0]  mq_q,       mq_d;
    logic [EXP_W-1:0]  op_exp_q,   op_exp_d;
    logic [FRAC_W-1:0] op_frac_q,  op_frac_d;
    logic              ready_q,    ready_d;
    logic [EXP_W-1:0]  o_exp_q,    o_exp_d;
    logic [FRAC_W-1:0] o_frac_q,   o_frac_d;

    // Combinational helpers
    logic [PROD_W-1:0]       acc_step;
    logic                    p_top;
    logic [FRAC_W-1:0]       frac_pre;
    logic                    guard;
    logic                    sticky;
    logic                    rnd_inc;
    logic                    rnd_carry;
    logic [FRAC_W:0]         frac_sum;
    logic signed [EW-1:0]    e_base;
    logic signed [EW-1:0]    e_norm;
    logic signed [EW-1:0]    e_fin;
    logic [EXP_W-1:0]        norm_exp;
    logic [FRAC_W-1:0]       norm_frac;
    logic [EXP_W-1:0]        spec_exp;
    logic [FRAC_W-1:0]       spec_frac;
    logic                    is_special;

    // The operand sign never affects a square; guard/sticky only feed the
    // rounding increment when nearest-even rounding is built in.
    logic [2:0] unused_bits;
    assign unused_bits = {i_sign, guard, sticky};

    // One shift-add step: acc = 2*acc + (next multiplier bit ? m : 0)
    always_comb begin
        acc_step = {acc_q[PROD_W-2:0], 1'b0}
                 + (mq_q[FRAC_W] ? {{SIG_W{1'b0}}, 1'b1, op_frac_q} : {PROD_W{1'b0}});
    end

    // Normalise the finished product, round it and clamp the exponent range
    always_comb begin
        p_top  = acc_q[PROD_W-1];
        e_base = $signed({1'b0, op_exp_q, 1'b0}) - BIAS_S;

        if (p_top) begin
            // Product in [2,4): hidden bit at PROD_W-1, exponent bumps by one
            frac_pre = acc_q[PROD_W-2 -: FRAC_W];
            guard    = acc_q[PROD_W-2-FRAC_W];
            sticky   = |acc_q[PROD_W-3-FRAC_W:0];
            e_norm   = e_base + ONE_S;
        end else begin
            frac_pre = acc_q[PROD_W-3 -: FRAC_W];
            guard    = acc_q[PROD_W-3-FRAC_W];
            sticky   = |acc_q[PROD_W-4-FRAC_W:0];
            e_norm   = e_base;
        end

`ifdef FP_SQUARE_RNE_EN
        rnd_inc = guard & (sticky | frac_pre[0]);
`else
        rnd_inc = 1'b0;
`endif

        frac_sum  = {1'b0, frac_pre} + {{FRAC_W{1'b0}}, rnd_inc};
        rnd_carry = frac_sum[FRAC_W];
        e_fin     = rnd_carry ? (e_norm + ONE_S) : e_norm;

        if (e_fin >= EMAX_S) begin
            norm_exp  = '1;
            norm_frac = '0;
        end else if (e_fin <= ZERO_S) begin
            // No subnormal outputs: anything below the normal range is +0
            norm_exp  = '0;
            norm_frac = '0;
        end else begin
            norm_exp  = e_fin[EXP_W-1:0];
            norm_frac = rnd_carry ? '0 : frac_sum[FRAC_W-1:0];
        end
    end

    // Special-case result from the latched operand (zero/subnormal, inf, NaN)
    always_comb begin
        if (op_exp_q == '0) begin
            spec_exp  = '0;
            spec_frac = '0;
        end else if (op_frac_q == '0) begin
            spec_exp  = '1;
            spec_frac = '0;
        end else begin
            // Quiet the NaN by forcing the top fraction bit, keep the payload
            spec_exp  = '1;
            spec_frac = {1'b1, op_frac_q[FRAC_W-2:0]};
        end
    end

    // Operand classification at accept time
    always_comb begin
        is_special = (i_exp == '0) || (i_exp == '1);
    end

    // Next-state logic for the control FSM and all datapath registers
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        op_exp_d  = op_exp_q;
        op_frac_d = op_frac_q;
        ready_d   = ready_q;
        o_exp_d   = o_exp_q;
        o_frac_d  = o_frac_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_exp_d  = i_exp;
                    op_frac_d = i_frac;
                    mq_d      = {1'b1, i_frac};
                    acc_d     = '0;
                    cnt_d     = '0;
                    ready_d   = 1'b0;
                    state_d   = is_special ? S_SPEC : S_MUL;
                end
            end
            S_MUL: begin
                acc_d = acc_step;
                mq_d  = {mq_q[SIG_W-2:0], 1'b0};
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_NORM: begin
                o_exp_d  = norm_exp;
                o_frac_d = norm_frac;
                ready_d  = 1'b1;
                state_d  = S_DONE;
            end
            S_SPEC: begin
                // Two cycles in SPEC give specials a fixed two-edge latency;
                // the first cycle only lets the decode settle from the latch.
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d    = '0;
                    o_exp_d  = spec_exp;
                    o_frac_d = spec_frac;
                    ready_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register update; reset aborts any operation and clears the outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            op_exp_q  <= '0;
            op_frac_q <= '0;
            ready_q   <= 1'b0;
            o_exp_q   <= '0;
            o_frac_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            op_exp_q  <= op_exp_d;
            op_frac_q <= op_frac_d;
            ready_q   <= ready_d;
            o_exp_q   <= o_exp_d;
            o_frac_q  <= o_frac_d;
        end
    end

    assign ready  = ready_q;
    assign o_sign = 1'b0;
    assign o_exp  = o_exp_q;
    assign o_frac = o_frac_q;

endmodule

// File: tb/tb_fp_square.sv
// Scoreboard bench for fp_square: stimulus pushes the expected result of each
// accepted operand, a negedge monitor pops and compares whenever ready rises.
// The reference model squares the significand with plain wide arithmetic and
// rounds from the remainder. Follows FP_SQUARE_RNE_EN like the design.
module tb_fp_square;

    localparam int EXP_W  = 11;
    localparam int FRAC_W = 52;
    localparam int BIAS   = 1023;

    logic              clk    = 1'b0;
    logic              reset  = 1'b0;
    logic              start  = 1'b0;
    logic              i_sign = 1'b0;
    logic [EXP_W-1:0]  i_exp  = '0;
    logic [FRAC_W-1:0] i_frac = '0;
    logic              ready;
    logic              o_sign;
    logic [EXP_W-1:0]  o_exp;
    logic [FRAC_W-1:0] o_frac;

    fp_square #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .BIAS(BIAS)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .i_sign (i_sign),
        .i_exp  (i_exp),
        .i_frac (i_frac),
        .ready  (ready),
        .o_sign (o_sign),
        .o_exp  (o_exp),
        .o_frac (o_frac)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        int                lat;
        int                acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   txn   = 0;
    logic prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: exact square of the significand, normalise, round by remainder
    function automatic exp_t model(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
        exp_t         r;
        logic [105:0] m;
        logic [105:0] p;
        logic [105:0] q;
        int           ex;
        int           sh;
        r.acc_cyc = 0;
        if (e == 11'd0) begin
            r.e = '0; r.f = '0; r.lat = 2;
        end else if (e == 11'h7FF) begin
            r.e = 11'h7FF;
            r.f = (f == 52'd0) ? 52'd0 : (f | 52'h8000000000000);
            r.lat = 2;
        end else begin
            r.lat = 54;
            m  = {53'd0, 1'b1, f};
            p  = m * m;
            ex = 2 * int'(e) - BIAS;
            sh = (p >= (106'd1 << 105)) ? 53 : 52;
            if (sh == 53) ex++;
            q = p >> sh;
`ifdef FP_SQUARE_RNE_EN
            begin
                logic [105:0] rem;
                logic [105:0] half;
                rem  = p - (q << sh);
                half = 106'd1 << (sh - 1);
                if (rem > half || (rem == half && q[0])) q = q + 106'd1;
            end
`endif
            if (q >= (106'd1 << 53)) begin
                q = q >> 1;
                ex++;
            end
            if (ex >= 2047) begin
                r.e = 11'h7FF; r.f = '0;
            end else if (ex <= 0) begin
                r.e = '0; r.f = '0;
            end else begin
                r.e = ex[10:0];
                r.f = q[51:0];
            end
        end
        return r;
    endfunction

    // Monitor: one comparison set per result, triggered by ready rising
    always @(negedge clk) begin
        if (ready && !prev_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got exp=%0d frac=%h with no pending op, want none", o_exp, o_frac);
            end else begin
                mon_x = sb.pop_front();
                txn++;
                $display("txn %0d: exp=%0d frac=%h sign=%0b lat=%0d (want exp=%0d frac=%h lat=%0d)",
                         txn, o_exp, o_frac, o_sign, cyc - mon_x.acc_cyc, mon_x.e, mon_x.f, mon_x.lat);
                check("res_sign", 64'(o_sign), 64'd0);
                check("res_exp",  64'(o_exp),  64'(mon_x.e));
                check("res_frac", 64'(o_frac), 64'(mon_x.f));
                check("latency",  64'(cyc - mon_x.acc_cyc), 64'(mon_x.lat));
            end
        end
        prev_ready <= ready;
    end

    // Present an operand for one cycle (in IDLE/DONE) and queue its result
    task automatic issue(input logic s, input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
        exp_t x;
        x = model(e, f);
        x.acc_cyc = cyc + 1;
        sb.push_back(x);
        i_sign = s;
        i_exp  = e;
        i_frac = f;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        i_exp  = 11'($urandom);
        i_frac = 52'({$urandom, $urandom});
        check("ready_drop", 64'(ready), 64'd0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready) return;
        end
        total++;
        bad++;
        $display("FAIL ready_timeout: ready=%0b after 200 cycles, want 1", ready);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready),  64'd0);
        check("rst_sign",  64'(o_sign), 64'd0);
        check("rst_exp",   64'(o_exp),  64'd0);
        check("rst_frac",  64'(o_frac), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed operands, each issued back-to-back on the ready cycle
        issue(1'b0, 11'd1025, 52'h4000000000000); wait_ready();
        issue(1'b1, 11'd1024, 52'h8000000000000); wait_ready();
        issue(1'b0, 11'd1600, 52'h0);             wait_ready();
        issue(1'b1, 11'd400,  52'h123456789ABCD); wait_ready();
        issue(1'b0, 11'd0,    52'h1);             wait_ready();
        issue(1'b1, 11'h7FF,  52'h1);             wait_ready();
        issue(1'b0, 11'h7FF,  52'h0);             wait_ready();
        issue(1'b0, 11'd1023, 52'hFFFFFFFFFFFFF); wait_ready();
        issue(1'b0, 11'd1023, 52'h0000000000001); wait_ready();

        // A start during MUL must be ignored
        issue(1'b0, 11'd1030, 52'h3000000000000);
        repeat (9) @(negedge clk);
        i_exp  = 11'd1500;
        i_frac = 52'hABCDEF0123456;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_ready();

        // Reset mid-operation aborts with no result
        issue(1'b0, 11'd1100, 52'h5555555555555);
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready", 64'(ready),  64'd0);
        check("abort_exp",   64'(o_exp),  64'd0);
        check("abort_frac",  64'(o_frac), 64'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        check("abort_no_result", 64'(ready), 64'd0);
        issue(1'b1, 11'd1025, 52'h4000000000000); wait_ready();

        // Randomised operands, weighted toward the range edges
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 7))
                0:       e = 11'($urandom_range(0, 2047));
                1:       e = 11'($urandom_range(1530, 1540));
                2:       e = 11'($urandom_range(508, 515));
                default: e = 11'($urandom_range(700, 1300));
            endcase
            f = 52'({$urandom, $urandom});
            if ($urandom_range(0, 5) == 0) f = '1;
            issue(1'($urandom), e, f);
            wait_ready();
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
